restoring_divider_param: RTL and testbench
==========================================

Name: restoring_divider_param

Overview:
- Parametrised, multi-cycle restoring divider. Successor to the fixed 16-bit unsigned divider.
- Adds the following over the 16-bit block:
  - generic WIDTH
  - run-time signed/unsigned mode
  - a busy/valid handshake
  - explicit divide-by-zero and signed-overflow flags
  - a (WIDTH+1)-bit partial remainder, so divisors with MSB set divide correctly
- Sits between operand source logic and the display/readback path. Results are held stable until the next accepted start.

Parameters:
- WIDTH, 16, operand/result width in bits, legal range 4..32.
- SIGNED_EN, 1, 1 enables the signed_mode input; 0 ties signed mode off (unsigned only).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only on a rising clk edge where busy=0.
- signed_mode  in  1  1 = two's-complement operands; sampled with start; ignored if SIGNED_EN=0.
- dividend  in  WIDTH  sampled on the accepting edge.
- divisor  in  WIDTH  sampled on the accepting edge.
- busy  out  1  high from the cycle after acceptance until valid asserts.
- valid  out  1  one-cycle pulse; results are final in that cycle.
- quotient  out  WIDTH  registered result, held until next acceptance.
- remainder  out  WIDTH  registered result, held until next acceptance.
- div_by_zero  out  1  registered flag, updated with valid.
- overflow  out  1  registered flag, updated with valid.

Behaviour:
- Reset (edge with rst=1, regardless of state): state=IDLE; busy, valid, quotient, remainder, div_by_zero and overflow all 0; iteration counter 0. Any reset mid-operation aborts the operation, produces no valid, and the next start is accepted normally.
- States: IDLE, DIVIDE, FIXUP.
- IDLE:
  - start=1 and divisor!=0: latch magnitudes |dividend| and |divisor| (absolute value only when signed mode is active), the quotient sign (dividend MSB xor divisor MSB), the remainder sign (dividend MSB), and the overflow condition. Clear the accumulator (WIDTH+1 bits), set count=0, go to DIVIDE.
  - start=1 and divisor=0: stay in IDLE. Next edge sets quotient=all ones, remainder=dividend (raw bits), div_by_zero=1, overflow=0, valid=1 for one cycle. busy stays 0.
- DIVIDE, one iteration per edge:
  - shift {acc, q} left by 1.
  - trial = acc - divisor magnitude, computed at WIDTH+1 bits.
  - if trial is negative, restore: keep acc, set q LSB = 0.
  - otherwise: acc = trial, q LSB = 1.
  - count++. After WIDTH iterations (count = WIDTH-1 on that edge), go to FIXUP.
- FIXUP, one edge:
  - quotient = q, negated if the quotient sign is set.
  - remainder = acc[WIDTH-1:0], negated if the remainder sign is set.
  - div_by_zero=0, overflow=latched overflow, valid=1, busy drops to 0, go to IDLE.
- Latency: acceptance at edge E0 gives valid high in the cycle after edge E0+WIDTH+1. Normal operations take WIDTH+2 edges total; divide-by-zero takes 1 edge.
- Signed overflow: most-negative / -1 gives quotient=most-negative (bit pattern 100…0), remainder=0, overflow=1. This falls out of the magnitude path; the flag is the only extra logic.
- start while busy=1: ignored, no queuing, operands not resampled.
- A start in the valid cycle is legal, since state is IDLE by then. The new operation is accepted on that edge. Outputs keep the old results until the next FIXUP or divide-by-zero update.
- Operand inputs may change freely after the accepting edge.
- Unsigned mode: sign logic is bypassed; all values are treated as magnitudes.

Test Plan (WIDTH=16, SIGNED_EN=1):
- Unsigned 1000/7, start pulsed at edge 0: busy high edges 1..17; valid in the cycle after edge 17; quotient=142, remainder=6, both flags 0.
- Unsigned 0xFFFF/0x8001 (divisor MSB set): quotient=1, remainder=0x7FFE. Checks the WIDTH+1 accumulator.
- Signed -7/2: quotient=-3 (0xFFFD), remainder=-1 (0xFFFF). Signed 7/-2: quotient=0xFFFD, remainder=1.
- Signed 0x8000/0xFFFF: quotient=0x8000, remainder=0, overflow=1, valid after 18 edges.
- Divide by zero, 1234/0: one edge later, valid=1, quotient=0xFFFF, remainder=1234, div_by_zero=1, busy never asserted.
- Robustness:
  - assert rst at iteration 8 of 500/3: outputs 0, state IDLE, no valid pulse.
  - then start 500/3 and re-pulse start at iterations 2–5: only a single valid, quotient=166, remainder=2.

Source files
------------

// File: rtl/restoring_divider_param.sv
// Parametrised multi-cycle restoring divider with signed/unsigned mode.
// Ports: clk, rst, start, signed_mode, dividend, divisor -> busy, valid, quotient, remainder, div_by_zero, overflow.
module restoring_divider_param #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    count_q, count_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             oflag_q, oflag_d;

  logic             smode;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    count_d = count_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    oflag_d = oflag_q;

    smode = SIGNED_EN && signed_mode;
    a_neg = smode & dividend[WIDTH-1];
    b_neg = smode & divisor[WIDTH-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor : divisor;

    // acc never exceeds the divisor, so its top bit is always clear
    // before the shift; the WIDTH+1 trial keeps the borrow visible.
    shifted = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            oflag_d = 1'b0;
            valid_d = 1'b1;
          end else begin
            dvs_d   = b_mag;
            q_d     = a_mag;
            acc_d   = '0;
            count_d = '0;
            qsign_d = a_neg ^ b_neg;
            rsign_d = a_neg;
            ovf_d   = smode
                      && dividend == {1'b1, {(WIDTH-1){1'b0}}}
                      && divisor == '1;
            busy_d  = 1'b1;
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (trial[WIDTH]) begin
          acc_d = shifted;
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = trial;
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH-1)) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        quot_d  = qsign_q ? -q_q : q_q;
        rem_d   = rsign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        dbz_d   = 1'b0;
        oflag_d = ovf_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      count_q <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      oflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      count_q <= count_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      oflag_q <= oflag_d;
    end
  end

  assign busy        = busy_q;
  assign valid       = valid_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = oflag_q;
endmodule

// File: tb/tb_restoring_divider_param.sv
// Scoreboard bench for restoring_divider_param (WIDTH=16, signed enabled).
// Random and directed operations checked against an arithmetic reference.
module tb_restoring_divider_param;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  restoring_divider_param #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .dividend(dividend), .divisor(divisor), .busy(busy), .valid(valid),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic exp_t model(input bit sm, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, qq, rr;
    e.dz = 1'b0;
    e.ov = 1'b0;
    e.cyc = 0;
    if (b == 0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qq = sa / sb;
      rr = sa % sb;
      e.q  = qq[W-1:0];
      e.r  = rr[W-1:0];
      e.ov = (sa == -32768 && sb == -1);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      exp_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid at cycle %0d q=%h r=%h",
                 cyc, quotient, remainder);
      end else begin
        e = exp_q.pop_front();
        if (quotient !== e.q || remainder !== e.r
            || div_by_zero !== e.dz || overflow !== e.ov
            || busy !== 1'b0 || cyc != e.cyc) begin
          fails++;
          $display("FAIL result got q=%h r=%h dz=%b ov=%b busy=%b cyc=%0d want q=%h r=%h dz=%b ov=%b busy=0 cyc=%0d",
                   quotient, remainder, div_by_zero, overflow, busy, cyc,
                   e.q, e.r, e.dz, e.ov, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic issue(input bit sm, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit push);
    exp_t e;
    e = model(sm, a, b);
    e.cyc = cyc + ((b == 0) ? 1 : W + 2);
    signed_mode = sm;
    dividend = a;
    divisor = b;
    start = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    #1;
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
    signed_mode = 1'($urandom);
    chk("busy_after_accept", {15'd0, busy}, {15'd0, (b != 0)});
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout waiting for valid, %0d pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {quotient | remainder},
        16'h0);
    chk("reset_flags", {12'd0, busy, valid, div_by_zero, overflow}, 16'h0);
    rst = 1'b0;
    #1;

    issue(1'b0, 16'd1000, 16'd7, 1'b1);
    wait_done();
    chk("u1000_7_q", quotient, 16'd142);
    chk("u1000_7_r", remainder, 16'd6);
    issue(1'b0, 16'hFFFF, 16'h8001, 1'b1);
    wait_done();
    chk("msb_divisor_q", quotient, 16'h0001);
    chk("msb_divisor_r", remainder, 16'h7FFE);
    issue(1'b1, 16'hFFF9, 16'd2, 1'b1);
    wait_done();
    issue(1'b1, 16'd7, 16'hFFFE, 1'b1);
    wait_done();
    issue(1'b1, 16'h8000, 16'hFFFF, 1'b1);
    wait_done();
    chk("ovf_q", quotient, 16'h8000);
    chk("ovf_flag", {15'd0, overflow}, 16'h1);
    issue(1'b0, 16'd1234, 16'd0, 1'b1);
    wait_done();
    chk("dz_r", remainder, 16'd1234);

    // Abort mid-operation: no valid may follow.
    issue(1'b0, 16'd500, 16'd3, 1'b0);
    repeat (8) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk("abort_outputs", quotient | remainder, 16'h0);
    chk("abort_flags", {12'd0, busy, valid, div_by_zero, overflow}, 16'h0);
    repeat (25) @(negedge clk);
    #1;

    // Starts while busy must be ignored.
    issue(1'b0, 16'd500, 16'd3, 1'b1);
    @(negedge clk);
    #1;
    dividend = 16'd9;
    divisor = 16'd2;
    start = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    start = 1'b0;
    wait_done();
    chk("repulse_q", quotient, 16'd166);
    chk("repulse_r", remainder, 16'd2);
    repeat (25) @(negedge clk);
    #1;

    for (int n = 0; n < 150; n++) begin
      bit           sm;
      logic [W-1:0] a, b;
      int           k;
      sm = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      k = $urandom_range(0, 9);
      if (k == 0) b = '0;
      if (k == 1) begin
        sm = 1'b1;
        a = 16'h8000;
        b = 16'hFFFF;
      end
      if (k == 2) b = W'($urandom_range(1, 5));
      issue(sm, a, b, 1'b1);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      #1;
    end

    repeat (25) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
